// File: rtl/ab_stim_gen.sv
// Two-bit {A,B} stimulus replayer with per-symbol Z response checking.
// Symbols come from a small write-protected memory; Z mismatches are counted with saturation.
module ab_stim_gen #(
   parameter  int DEPTH = 8,
   parameter  int CNT_W = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             WR_EN,
   input  logic [AW-1:0]    WR_ADDR,
   input  logic [2:0]       WR_DATA,
   input  logic [AW:0]      LEN,
   input  logic [CNT_W-1:0] HOLD,
   input  logic [CNT_W-1:0] LOOPS,
   input  logic             START,
   input  logic             ABORT,
   input  logic             Z,
   output logic             A,
   output logic             B,
   output logic             BUSY,
   output logic             SYM_STRB,
   output logic [AW-1:0]    SYM_IDX,
   output logic             DONE,
   output logic [CNT_W-1:0] ERR_CNT
);

   typedef enum logic {IDLE, DRIVE} state_t;

   localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

   state_t           state_q, state_d;
   logic [2:0]       mem_q [DEPTH];
   logic [2:0]       mem_d [DEPTH];
   logic [AW:0]      len_q, len_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] loops_q, loops_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0] pass_q, pass_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic             a_q, a_d, b_q, b_d;
   logic             busy_q, busy_d, strb_q, strb_d, done_q, done_d;

   logic [CNT_W-1:0] hold_eff;
   logic [AW-1:0]    idx_nxt;
   logic             len_ok, win_last, sym_last, pass_last;

   // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_d    = state_q;
      mem_d      = mem_q;
      len_d      = len_q;
      hold_d     = hold_q;
      loops_d    = loops_q;
      hold_cnt_d = hold_cnt_q;
      pass_d     = pass_q;
      err_d      = err_q;
      idx_d      = idx_q;
      a_d        = a_q;
      b_d        = b_q;
      busy_d     = busy_q;
      strb_d     = 1'b0;
      done_d     = 1'b0;
      idx_nxt    = '0;

      len_ok    = (LEN != '0) && (LEN <= DEPTH_LEN);
      hold_eff  = (hold_q == '0) ? CNT_W'(1) : hold_q;
      win_last  = (hold_cnt_q == hold_eff - 1'b1);
      sym_last  = ({1'b0, idx_q} == len_q - 1'b1);
      pass_last = (pass_q == loops_q);

      case (state_q)
         IDLE: begin
            if (WR_EN) mem_d[WR_ADDR] = WR_DATA;
            if (START && !ABORT && len_ok) begin
               state_d    = DRIVE;
               len_d      = LEN;
               hold_d     = HOLD;
               loops_d    = LOOPS;
               idx_d      = '0;
               pass_d     = '0;
               hold_cnt_d = '0;
               err_d      = '0;
               busy_d     = 1'b1;
               strb_d     = 1'b1;
               a_d        = mem_q[0][2];
               b_d        = mem_q[0][1];
            end
         end
         DRIVE: begin
            if (ABORT) begin
               // Window in progress is abandoned unchecked; ERR_CNT keeps its value.
               state_d = IDLE;
               busy_d  = 1'b0;
               a_d     = 1'b0;
               b_d     = 1'b0;
            end else if (win_last) begin
               if ((Z != mem_q[idx_q][0]) && (err_q != '1)) err_d = err_q + 1'b1;
               hold_cnt_d = '0;
               if (sym_last && pass_last) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  a_d     = 1'b0;
                  b_d     = 1'b0;
               end else begin
                  idx_nxt = sym_last ? '0 : idx_q + 1'b1;
                  idx_d   = idx_nxt;
                  if (sym_last) pass_d = pass_q + 1'b1;
                  strb_d  = 1'b1;
                  a_d     = mem_q[idx_nxt][2];
                  b_d     = mem_q[idx_nxt][1];
               end
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         // NOTE: the symbol memory is reset too, because a run after reset must replay all-zero symbols.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         len_q      <= '0;
         hold_q     <= '0;
         loops_q    <= '0;
         hold_cnt_q <= '0;
         pass_q     <= '0;
         err_q      <= '0;
         idx_q      <= '0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         busy_q     <= 1'b0;
         strb_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_q      <= mem_d;
         len_q      <= len_d;
         hold_q     <= hold_d;
         loops_q    <= loops_d;
         hold_cnt_q <= hold_cnt_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         idx_q      <= idx_d;
         a_q        <= a_d;
         b_q        <= b_d;
         busy_q     <= busy_d;
         strb_q     <= strb_d;
         done_q     <= done_d;
      end
   end

   assign A        = a_q;
   assign B        = b_q;
   assign BUSY     = busy_q;
   assign SYM_STRB = strb_q;
   assign SYM_IDX  = idx_q;
   assign DONE     = done_q;
   assign ERR_CNT  = err_q;

endmodule

// File: tb/tb_ab_stim_gen.sv
// Directed bench for ab_stim_gen; Z comes from a tiny detector stand-in (Z = A^B, optionally inverted).
// A second instance with CNT_W=2 shares all inputs and is used for the saturation check.
module tb_ab_stim_gen;

   logic       clk, rst_n;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [2:0] wr_data;
   logic [3:0] len;
   logic [7:0] hold, loops;
   logic       start, abort;
   logic       z, z_inv;
   logic       a, b, busy, sym_strb, done;
   logic [2:0] sym_idx;
   logic [7:0] err_cnt;
   logic       a2, b2, busy2, sym_strb2, done2;
   logic [2:0] sym_idx2;
   logic [1:0] err_cnt2;

   int n_checks = 0;
   int n_errors = 0;

   logic [1:0] tab_ab [8];

   assign z = z_inv ? ~(a ^ b) : (a ^ b);

   ab_stim_gen #(.DEPTH(8), .CNT_W(8)) dut (
      .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
      .LEN(len), .HOLD(hold), .LOOPS(loops), .START(start), .ABORT(abort), .Z(z),
      .A(a), .B(b), .BUSY(busy), .SYM_STRB(sym_strb), .SYM_IDX(sym_idx),
      .DONE(done), .ERR_CNT(err_cnt)
   );

   ab_stim_gen #(.DEPTH(8), .CNT_W(2)) dut2 (
      .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
      .LEN(len), .HOLD(hold[1:0]), .LOOPS(loops[1:0]), .START(start), .ABORT(abort), .Z(z),
      .A(a2), .B(b2), .BUSY(busy2), .SYM_STRB(sym_strb2), .SYM_IDX(sym_idx2),
      .DONE(done2), .ERR_CNT(err_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " busy"}, busy, 0);
      check({tag, " ab"}, {a, b}, 0);
      check({tag, " strb"}, sym_strb, 0);
      check({tag, " idx"}, sym_idx, 0);
      check({tag, " done"}, done, 0);
      check({tag, " err"}, err_cnt, 0);
   endtask

   // Writes all 8 entries with Zexp = A^B, flipped where mism_mask has a 1.
   task automatic load_table(input logic [7:0] mism_mask);
      for (int i = 0; i < 8; i++) begin
         wr_en   = 1'b1;
         wr_addr = 3'(i);
         wr_data = {tab_ab[i], (tab_ab[i][1] ^ tab_ab[i][0]) ^ mism_mask[i]};
         tick();
      end
      wr_en = 1'b0;
   endtask

   // Starts a run, scrambles the live settings, checks every cycle, ends in the DONE cycle.
   task automatic do_run(input int l, input int h, input int lp, input int exp_err, input string tag);
      int heff;
      heff  = (h == 0) ? 1 : h;
      len   = 4'(l);
      hold  = 8'(h);
      loops = 8'(lp);
      start = 1'b1;
      tick();
      start = 1'b0;
      len   = 4'd1;
      hold  = 8'd2;
      loops = 8'd7;
      for (int p = 0; p <= lp; p++)
         for (int s = 0; s < l; s++)
            for (int c = 0; c < heff; c++) begin
               check({tag, " busy"}, busy, 1);
               check({tag, " idx"}, sym_idx, s);
               check({tag, " ab"}, {a, b}, tab_ab[s]);
               check({tag, " strb"}, sym_strb, (c == 0));
               check({tag, " done early"}, done, 0);
               tick();
            end
      check({tag, " done"}, done, 1);
      check({tag, " busy end"}, busy, 0);
      check({tag, " ab end"}, {a, b}, 0);
      check({tag, " err"}, err_cnt, exp_err);
   endtask

   task automatic gap(input string tag);
      tick();
      check({tag, " done one cycle"}, done, 0);
      check({tag, " idle busy"}, busy, 0);
   endtask

   initial begin
      tab_ab = '{2'b00, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b10};
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      len = '0; hold = '0; loops = '0; start = 1'b0; abort = 1'b0; z_inv = 1'b0;
      #12;
      check_idle_outputs("reset");
      rst_n = 1'b1;
      tick();

      load_table(8'h00);
      do_run(8, 1, 0, 0, "nominal");
      gap("nominal");

      load_table(8'b0010_0100);
      do_run(8, 1, 0, 2, "mism");
      gap("mism");
      do_run(8, 1, 3, 8, "mism loops3");
      gap("mism loops3");

      // Back-to-back: second START lands in the DONE cycle; ERR_CNT must restart from 0.
      do_run(8, 1, 0, 2, "b2b first");
      do_run(8, 1, 0, 2, "b2b second");
      gap("b2b");

      load_table(8'h00);
      do_run(4, 3, 0, 0, "hold3");
      gap("hold3");
      do_run(8, 0, 0, 0, "hold0");
      gap("hold0");

      // Abort in cycle 5 of an 8-symbol run, with a blocked write in cycle 2.
      load_table(8'b0010_0100);
      len = 4'd8; hold = 8'd1; loops = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 3'b111;
      tick();
      wr_en = 1'b0;
      tick(); tick(); tick();
      check("abort pre idx", sym_idx, 4);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort busy", busy, 0);
      check("abort ab", {a, b}, 0);
      check("abort done", done, 0);
      check("abort err hold", err_cnt, 1);
      tick();
      check("abort no done later", done, 0);
      check("abort err stable", err_cnt, 1);
      do_run(8, 1, 0, 2, "after abort");
      gap("after abort");

      len = 4'd0; start = 1'b1;
      tick();
      check("len0 busy", busy, 0);
      len = 4'd9;
      tick();
      check("len9 busy", busy, 0);
      len = 4'd8; abort = 1'b1;
      tick();
      check("start+abort busy", busy, 0);
      start = 1'b0; abort = 1'b0;
      tick();
      check("boundary idle", busy, 0);

      load_table(8'h00);
      z_inv = 1'b1;
      do_run(8, 1, 0, 8, "sat wide");
      check("sat narrow", err_cnt2, 3);
      z_inv = 1'b0;
      gap("sat");

      // Asynchronous reset between edges in the middle of a run.
      load_table(8'b0010_0100);
      len = 4'd8; hold = 8'd1; loops = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick(); tick();
      check("pre reset busy", busy, 1);
      check("pre reset err", err_cnt, 1);
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("async reset");
      #3 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) tab_ab[i] = 2'b00;
      do_run(8, 1, 0, 0, "post reset");
      gap("post reset");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
